// File: rtl/fifo_fill_ctrl.sv
// fifo_fill_ctrl: reads NUM_WORDS memory words and unpacks each, lowest byte first, into its own byte FIFO.
// Optional macro FIFO_FILL_STALL_CNT_EN adds a saturating 16-bit stall-cycle counter output (stall_cnt).
module fifo_fill_ctrl #(
   parameter int unsigned            DATA_WIDTH = 8,
   parameter int unsigned            WORD_BYTES = 8,
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            NUM_WORDS  = 9,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   output logic                             busy,
   output logic                             done,
   output logic                             read_mem,
   output logic [ADDR_WIDTH-1:0]            address,
   input  logic                             mem_wait,
   input  logic                             mem_valid,
   input  logic [DATA_WIDTH*WORD_BYTES-1:0] mem_data,
   input  logic [NUM_WORDS-1:0]             fifo_full,
   output logic [NUM_WORDS-1:0]             fifo_wren,
   output logic [DATA_WIDTH-1:0]            fifo_wdata
`ifdef FIFO_FILL_STALL_CNT_EN
   ,
   output logic [15:0]                      stall_cnt
`endif
);

   localparam int unsigned WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam int unsigned BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);
   localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(WORD_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_UNPACK = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   state_t                           state_r;
   state_t                           state_nxt_s;
   logic [WIDX_W-1:0]                word_idx_r;
   logic [WIDX_W-1:0]                word_idx_nxt_s;
   logic [BIDX_W-1:0]                byte_idx_r;
   logic [BIDX_W-1:0]                byte_idx_nxt_s;
   logic [DATA_WIDTH*WORD_BYTES-1:0] word_r;
   logic                             load_word_s;
   logic                             cur_full_s;

   // Only the FIFO owned by the current word can stall the unpacker.
   assign cur_full_s = fifo_full[word_idx_r];

   // State, counter and word-holding registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         word_idx_r <= '0;
         byte_idx_r <= '0;
         word_r     <= '0;
      end else begin
         state_r    <= state_nxt_s;
         word_idx_r <= word_idx_nxt_s;
         byte_idx_r <= byte_idx_nxt_s;
         if (load_word_s) begin
            word_r <= mem_data;
         end else begin
            word_r <= word_r;
         end
      end
   end

   // Next-state and counter sequencing.
   always_comb begin
      state_nxt_s    = state_r;
      word_idx_nxt_s = word_idx_r;
      byte_idx_nxt_s = byte_idx_r;
      load_word_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               word_idx_nxt_s = '0;
               state_nxt_s    = ST_REQ;
            end else begin
               state_nxt_s    = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (!mem_wait) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (mem_valid) begin
               load_word_s    = 1'b1;
               byte_idx_nxt_s = '0;
               state_nxt_s    = ST_UNPACK;
            end else begin
               state_nxt_s    = ST_WAIT;
            end
         end
         ST_UNPACK: begin
            if (cur_full_s) begin
               state_nxt_s = ST_UNPACK;
            end else if (byte_idx_r != LAST_BYTE) begin
               byte_idx_nxt_s = byte_idx_r + BIDX_W'(1);
            end else if (word_idx_r == LAST_WORD) begin
               byte_idx_nxt_s = '0;
               state_nxt_s    = ST_DONE;
            end else begin
               byte_idx_nxt_s = '0;
               word_idx_nxt_s = word_idx_r + WIDX_W'(1);
               state_nxt_s    = ST_REQ;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode; rst forces every output low in the same cycle.
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      read_mem   = 1'b0;
      address    = '0;
      fifo_wren  = '0;
      fifo_wdata = '0;
      if (!rst) begin
         busy = (state_r != ST_IDLE);
         done = (state_r == ST_DONE);
         if (state_r == ST_REQ) begin
            read_mem = 1'b1;
            address  = BASE_ADDR + ADDR_WIDTH'(word_idx_r);
         end else begin
            read_mem = 1'b0;
            address  = '0;
         end
         if (state_r == ST_UNPACK) begin
            fifo_wdata = word_r[byte_idx_r*DATA_WIDTH +: DATA_WIDTH];
            if (cur_full_s) begin
               fifo_wren = '0;
            end else begin
               fifo_wren = NUM_WORDS'(1'b1) << word_idx_r;
            end
         end else begin
            fifo_wdata = '0;
            fifo_wren  = '0;
         end
      end else begin
         busy = 1'b0;
      end
   end

`ifdef FIFO_FILL_STALL_CNT_EN
   logic [15:0] stall_cnt_r;
   logic        stall_s;

   // A stall is a refused request or a blocked byte write.
   always_comb begin
      stall_s = 1'b0;
      case (state_r)
         ST_REQ:    stall_s = mem_wait;
         ST_UNPACK: stall_s = cur_full_s;
         default:   stall_s = 1'b0;
      endcase
   end

   // Saturating stall counter, restarted by each accepted start.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= 16'h0000;
      end else if ((state_r == ST_IDLE) && start) begin
         stall_cnt_r <= 16'h0000;
      end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
         stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Self-checking bench for fifo_fill_ctrl: a protocol-level memory/FIFO model drives randomized stalls and
// checks each cycle's outputs plus final FIFO contents. Define FIFO_FILL_STALL_CNT_EN to also check stall_cnt.
module tb_fifo_fill_ctrl;
   localparam int DW = 8;
   localparam int WB = 8;
   localparam int AW = 32;
   localparam int NW = 9;

   logic             clk;
   logic             rst;
   logic             start;
   logic             busy;
   logic             done;
   logic             read_mem;
   logic [AW-1:0]    address;
   logic             mem_wait;
   logic             mem_valid;
   logic [DW*WB-1:0] mem_data;
   logic [NW-1:0]    fifo_full;
   logic [NW-1:0]    fifo_wren;
   logic [DW-1:0]    fifo_wdata;
`ifdef FIFO_FILL_STALL_CNT_EN
   logic [15:0]      stall_cnt;
`endif

   fifo_fill_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .read_mem   (read_mem),
      .address    (address),
      .mem_wait   (mem_wait),
      .mem_valid  (mem_valid),
      .mem_data   (mem_data),
      .fifo_full  (fifo_full),
      .fifo_wren  (fifo_wren),
      .fifo_wdata (fifo_wdata)
`ifdef FIFO_FILL_STALL_CNT_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents and per-fill stall plans.
   logic [63:0] mem_words [NW];
   int          lat_plan  [NW];
   int          wait_plan [NW];
   int          full_plan [NW][WB];
   int          read_cycles [NW];
   logic [7:0]  got [NW][$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Protocol model state: what the block should be doing next.
   bit active = 0, req_pend = 0, outst = 0, unpack = 0, done_now = 0, resp_now = 0;
   int req_word = 0, wait_left = 0, lat_left = 0, resp_word = 0;
   int cur_word = 0, cur_byte = 0, full_left = 0;
   int stall_exp = 0, start_cyc = 0, dut_done_cyc = 0, dut_done_cnt = 0;
   bit inj_valid_en = 0, noise_en = 0, stale_valid = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, sample at negedge, advance the model.
   task automatic tick();
      logic [NW-1:0] exp_wren;
      logic [7:0]    exp_b;
      bit a, r, u, d, rn;
      resp_now  = 0;
      mem_valid = 1'b0;
      mem_data  = {$urandom(), $urandom()};
      if (outst) begin
         lat_left--;
         if (lat_left == 0) begin
            resp_now  = 1;
            mem_valid = 1'b1;
            mem_data  = mem_words[resp_word];
         end
      end else if (stale_valid) begin
         mem_valid = 1'b1;
      end else if (inj_valid_en && req_pend && ($urandom_range(0, 2) == 0)) begin
         mem_valid = 1'b1;
      end
      if (req_pend) mem_wait = (wait_left > 0);
      else          mem_wait = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      fifo_full = noise_en ? NW'($urandom()) & NW'($urandom()) : '0;
      if (unpack) fifo_full[cur_word] = (full_left > 0);

      @(negedge clk);
      if (rst) begin
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_read_mem", read_mem, 0);
         check("rst_address", address, 0);
         check("rst_fifo_wren", fifo_wren, 0);
         check("rst_fifo_wdata", fifo_wdata, 0);
      end else begin
         exp_wren = '0;
         if (unpack && !fifo_full[cur_word]) exp_wren[cur_word] = 1'b1;
         exp_b = unpack ? mem_words[cur_word][cur_byte*8 +: 8] : 8'h00;
         check("busy", busy, active);
         check("done", done, done_now);
         check("read_mem", read_mem, req_pend);
         if (req_pend) check("address", address, 64'(req_word));
         check("fifo_wren", fifo_wren, exp_wren);
         check("fifo_wdata", fifo_wdata, exp_b);
         for (int i = 0; i < NW; i++) if (fifo_wren[i]) got[i].push_back(fifo_wdata);
         if (done) begin
            dut_done_cnt++;
            dut_done_cyc = cyc;
         end
      end

      if (rst) begin
         active = 0; req_pend = 0; outst = 0; unpack = 0; done_now = 0; stall_exp = 0;
      end else begin
         a = active; r = req_pend; u = unpack; d = done_now; rn = resp_now;
         if (d) begin
            done_now = 0;
            active   = 0;
         end
         if (start && !a) begin
            active = 1; req_pend = 1; req_word = 0; wait_left = wait_plan[0];
            stall_exp = 0; start_cyc = cyc;
         end
         if (r) begin
            read_cycles[req_word]++;
            if (mem_wait) begin
               wait_left--;
               stall_exp++;
            end else begin
               req_pend = 0; outst = 1; lat_left = lat_plan[req_word]; resp_word = req_word;
            end
         end
         if (rn) begin
            outst = 0; unpack = 1; cur_word = resp_word; cur_byte = 0;
            full_left = full_plan[cur_word][0];
         end
         if (u) begin
            if (fifo_full[cur_word]) begin
               full_left--;
               stall_exp++;
            end else begin
               cur_byte++;
               if (cur_byte == WB) begin
                  unpack = 0;
                  if (cur_word == NW - 1) begin
                     done_now = 1;
                  end else begin
                     req_pend = 1; req_word = cur_word + 1; wait_left = wait_plan[req_word];
                  end
               end else begin
                  full_left = full_plan[cur_word][cur_byte];
               end
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_plan(input int lat);
      for (int i = 0; i < NW; i++) begin
         lat_plan[i] = lat; wait_plan[i] = 0; read_cycles[i] = 0;
         got[i].delete();
         for (int b = 0; b < WB; b++) full_plan[i][b] = 0;
      end
   endtask

   task automatic pattern_words();
      for (int i = 0; i < NW; i++)
         for (int b = 0; b < WB; b++) mem_words[i][b*8 +: 8] = 8'((i << 4) | b);
   endtask

   function automatic int expected_latency();
      int t;
      t = 1;
      for (int i = 0; i < NW; i++) begin
         t += 1 + wait_plan[i] + lat_plan[i] + WB;
         for (int b = 0; b < WB; b++) t += full_plan[i][b];
      end
      return t;
   endfunction

   task automatic run_fill(input string tag, input int mid_start);
      int n;
      dut_done_cnt = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (active && n < 3000) begin
         if (n == mid_start) start = 1'b1;
         tick();
         start = 1'b0;
         n++;
      end
      tick();
      tick();
      check({tag, "_done_pulses"}, dut_done_cnt, 1);
      check({tag, "_done_cycle"}, dut_done_cyc - start_cyc, expected_latency());
`ifdef FIFO_FILL_STALL_CNT_EN
      check({tag, "_stall_cnt"}, stall_cnt, stall_exp);
`endif
   endtask

   task automatic check_contents(input string tag);
      for (int i = 0; i < NW; i++) begin
         check({tag, "_fifo_len"}, got[i].size(), WB);
         for (int b = 0; b < WB && b < got[i].size(); b++)
            check({tag, "_fifo_byte"}, got[i][b], mem_words[i][b*8 +: 8]);
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; mem_wait = 1'b0; mem_valid = 1'b0;
      mem_data = '0; fifo_full = '0;
      clear_plan(1);
      pattern_words();
      @(posedge clk);
      #1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();

      // Basic fill: L=1, no stalls, done 91 cycles after start.
      clear_plan(1);
      run_fill("basic", -1);
      check("basic_done_at_91", dut_done_cyc - start_cyc, 91);
      check_contents("basic");

      // Waitrequest on word 2 for 3 cycles.
      clear_plan(1);
      wait_plan[2] = 3;
      run_fill("wait", -1);
      check("wait_req_cycles_w2", read_cycles[2], 4);
      check_contents("wait");

      // Backpressure: FIFO 4 full for 5 cycles while byte 3 pending.
      clear_plan(1);
      full_plan[4][3] = 5;
      run_fill("bp", -1);
      check_contents("bp");

      // Ignored inputs: start mid-fill, mem_valid injected in REQ, noise on other flags.
      clear_plan(1);
      inj_valid_en = 1; noise_en = 1;
      run_fill("ignore", 30);
      check_contents("ignore");

      // Randomized latencies, waitstates, backpressure and data.
      for (int rep = 0; rep < 3; rep++) begin
         clear_plan(1);
         for (int i = 0; i < NW; i++) begin
            mem_words[i] = {$urandom(), $urandom()};
            lat_plan[i]  = $urandom_range(1, 3);
            wait_plan[i] = $urandom_range(0, 2);
            for (int b = 0; b < WB; b++)
               full_plan[i][b] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         end
         run_fill("rand", $urandom_range(5, 60));
         check_contents("rand");
      end

      // Reset during UNPACK of word 5, then a stale mem_valid, then a clean refill.
      clear_plan(2);
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!(unpack && cur_word == 5 && cur_byte == 2) && n < 2000) begin
         tick();
         n++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      stale_valid = 1;
      tick();
      stale_valid = 0;
`ifdef FIFO_FILL_STALL_CNT_EN
      check("rst_stall_cnt", stall_cnt, 0);
`endif
      tick();
      tick();
      inj_valid_en = 0; noise_en = 0;
      clear_plan(1);
      pattern_words();
      run_fill("refill", -1);
      check_contents("refill");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
